// File: rtl/serial_magnitude_comparator_if.sv
// Bundle of request, operand and result signals for serial_magnitude_comparator.
// Handshake: the requester raises compare_start. The request is taken on any edge where the DUT is idle (dbg_scan=0).
// busy stays high while digits are scanned. is_compare_done pulses for one cycle, and the flags and compare_cycles hold until the next accept.
interface serial_magnitude_comparator_if #(
  parameter int DATA_W = 9,
  parameter int LEN_W  = $clog2(DATA_W + 1)
);
  logic              compare_start;
  logic [LEN_W-1:0]  num_of_bits;
  logic              signed_mode;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              busy;
  logic              is_compare_done;
  logic              is_equal;
  logic              is_greater;
  logic              is_less_than;
  logic [LEN_W-1:0]  compare_cycles;
  logic              dbg_scan;

  modport master (
    output compare_start, num_of_bits, signed_mode, A, B,
    input  busy, is_compare_done, is_equal, is_greater, is_less_than,
           compare_cycles, dbg_scan
  );

  modport slave (
    input  compare_start, num_of_bits, signed_mode, A, B,
    output busy, is_compare_done, is_equal, is_greater, is_less_than,
           compare_cycles, dbg_scan
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// MSB-first multi-cycle magnitude comparator, DIGIT_W bits per clock, with an early exit
// at the first differing digit. The compare can be unsigned or two's-complement.
module serial_magnitude_comparator #(
  parameter int DATA_W  = 9,
  parameter int DIGIT_W = 1,
  parameter int LEN_W   = $clog2(DATA_W + 1)
) (
  input logic clk,
  input logic reset,
  serial_magnitude_comparator_if.slave cmp
);
  localparam int NDIG  = (DATA_W + DIGIT_W - 1) / DIGIT_W;
  localparam int PAD_W = NDIG * DIGIT_W;
  localparam int PTR_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state;
  logic [PAD_W-1:0]   a_q, b_q, a_lat, b_lat, a_shift, b_shift;
  logic [PTR_W-1:0]   d_q, d_init;
  logic [LEN_W-1:0]   len_clamped;
  logic [LEN_W-1:0]   cycles_q;
  logic [DIGIT_W-1:0] a_dig, b_dig;
  logic               busy_q, done_q, eq_q, gt_q, lt_q;

  // Inverting the sign bit of both operands maps two's-complement order onto unsigned order.
  always_comb begin
    len_clamped = cmp.num_of_bits;
    if (int'(cmp.num_of_bits) > DATA_W) len_clamped = LEN_W'(DATA_W);
    a_lat = '0;
    b_lat = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(len_clamped)) begin
        a_lat[i] = cmp.A[i];
        b_lat[i] = cmp.B[i];
      end
    end
    if (cmp.signed_mode && (len_clamped != '0)) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (i == int'(len_clamped) - 1) begin
          a_lat[i] = ~a_lat[i];
          b_lat[i] = ~b_lat[i];
        end
      end
    end
    d_init = '0;
    if (len_clamped != '0) d_init = PTR_W'((int'(len_clamped) + DIGIT_W - 1) / DIGIT_W - 1);
    a_shift = a_q >> (int'(d_q) * DIGIT_W);
    b_shift = b_q >> (int'(d_q) * DIGIT_W);
    a_dig   = a_shift[DIGIT_W-1:0];
    b_dig   = b_shift[DIGIT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      cycles_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmp.compare_start) begin
            a_q      <= a_lat;
            b_q      <= b_lat;
            d_q      <= d_init;
            cycles_q <= '0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            busy_q   <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (cycles_q != '1) cycles_q <= cycles_q + 1'b1;
          if ((a_dig != b_dig) || (d_q == '0)) begin
            gt_q   <= (a_dig > b_dig);
            lt_q   <= (a_dig < b_dig);
            eq_q   <= (a_dig == b_dig);
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            d_q <= d_q - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmp.busy            = busy_q;
  assign cmp.is_compare_done = done_q;
  assign cmp.is_equal        = eq_q;
  assign cmp.is_greater      = gt_q;
  assign cmp.is_less_than    = lt_q;
  assign cmp.compare_cycles  = cycles_q;
  assign cmp.dbg_scan        = (state == SCAN);
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator with one DIGIT_W=1 instance and one DIGIT_W=4 instance.
// Results are scoreboarded as {is_equal, is_greater, is_less_than, compare_cycles}.
module tb_serial_magnitude_comparator;
  localparam int DATA_W = 9;
  localparam int LEN_W  = 4;
  localparam int W      = 3 + LEN_W;
  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic clk;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp4_q[$];

  serial_magnitude_comparator_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) if1 ();
  serial_magnitude_comparator_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) if4 ();

  serial_magnitude_comparator #(.DATA_W(DATA_W), .DIGIT_W(1), .LEN_W(LEN_W)) u_dut1 (
    .clk(clk), .reset(reset), .cmp(if1.slave));
  serial_magnitude_comparator #(.DATA_W(DATA_W), .DIGIT_W(4), .LEN_W(LEN_W)) u_dut4 (
    .clk(clk), .reset(reset), .cmp(if4.slave));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!reset && if1.is_compare_done) begin
      if (exp1_q.size() == 0) check("u1_unexpected_done", 1, 0);
      else check("u1_result", 32'({if1.is_equal, if1.is_greater, if1.is_less_than,
                                   if1.compare_cycles}), 32'(exp1_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!reset && if4.is_compare_done) begin
      if (exp4_q.size() == 0) check("u4_unexpected_done", 1, 0);
      else check("u4_result", 32'({if4.is_equal, if4.is_greater, if4.is_less_than,
                                   if4.compare_cycles}), 32'(exp4_q.pop_front()));
    end
  end

  // Drivers: call just after a negedge; returns #1 after the accept edge.
  task automatic issue(input int sel, input int len, input bit sgn, input int a, input int b,
                       input logic [2:0] flags, input int cyc, input bit push);
    if (sel == 1) begin
      if1.num_of_bits = LEN_W'(len); if1.signed_mode = sgn;
      if1.A = DATA_W'(a); if1.B = DATA_W'(b); if1.compare_start = 1'b1;
      if (push) exp1_q.push_back({flags, LEN_W'(cyc)});
    end else begin
      if4.num_of_bits = LEN_W'(len); if4.signed_mode = sgn;
      if4.A = DATA_W'(a); if4.B = DATA_W'(b); if4.compare_start = 1'b1;
      if (push) exp4_q.push_back({flags, LEN_W'(cyc)});
    end
    @(posedge clk);
    #1;
    if1.compare_start = 1'b0;
    if4.compare_start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait_done(input int sel, output int busy_cycles);
    int n = 0;
    bit seen = 0;
    busy_cycles = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (sel == 1) begin
        if (if1.busy) busy_cycles++;
        seen = if1.is_compare_done;
      end else begin
        if (if4.busy) busy_cycles++;
        seen = if4.is_compare_done;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic run(input int sel, input int len, input bit sgn, input int a, input int b,
                     input logic [2:0] flags, input int cyc);
    int bc;
    @(negedge clk);
    issue(sel, len, sgn, a, b, flags, cyc, 1'b1);
    wait_done(sel, bc);
  endtask

  initial begin
    int bc;
    reset = 1'b1;
    if1.compare_start = 0; if1.num_of_bits = '0; if1.signed_mode = 0; if1.A = '0; if1.B = '0;
    if4.compare_start = 0; if4.num_of_bits = '0; if4.signed_mode = 0; if4.A = '0; if4.B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_u1_outputs", 32'({if1.busy, if1.is_compare_done, if1.is_equal, if1.is_greater,
                                   if1.is_less_than, if1.compare_cycles, if1.dbg_scan}), 0);
    check("reset_u4_outputs", 32'({if4.busy, if4.is_compare_done, if4.is_equal, if4.is_greater,
                                   if4.is_less_than, if4.compare_cycles, if4.dbg_scan}), 0);
    reset = 1'b0;

    // Digit width 1
    run(1, 8, 0, 'h80, 'h7F, GT, 1);
    repeat (3) @(negedge clk);
    check("flags_hold", 32'({if1.is_compare_done, if1.is_greater}), 32'b01);
    @(negedge clk);
    issue(1, 9, 0, 'h1A5, 'h1A5, EQ, 9, 1'b1);
    wait_done(1, bc);
    check("busy_cycles_l9", bc, 9);
    run(1, 8, 1, 'h80, 'h01, LT, 1);
    run(1, 8, 0, 'h80, 'h01, GT, 1);
    run(1, 8, 1, 'hFF, 'hFE, GT, 8);
    run(1, 0, 0, 'h1FF, 'h000, EQ, 1);
    run(1, 15, 0, 'h100, 'h000, GT, 1);
    run(1, 15, 0, 'h001, 'h000, GT, 9);

    // Digit width 4
    run(4, 9, 0, 'h123, 'h124, LT, 3);
    run(4, 5, 0, 'h1F0, 'h010, EQ, 2);
    run(4, 9, 1, 'h100, 'h0FF, LT, 1);
    run(4, 0, 1, 'h0AB, 'h1CD, EQ, 1);

    // Start during SCAN is ignored, as are operand changes
    @(negedge clk);
    issue(1, 9, 0, 'h1A5, 'h1A5, EQ, 9, 1'b1);
    repeat (2) @(negedge clk);
    if1.A = '0; if1.B = 9'h1FF; if1.num_of_bits = 4'd3; if1.compare_start = 1'b1;
    @(posedge clk);
    #1 if1.compare_start = 1'b0;
    wait_done(1, bc);
    repeat (12) @(negedge clk);

    // Back-to-back: start in the done cycle
    run(1, 4, 0, 5, 3, GT, 2);
    issue(1, 4, 0, 3, 5, LT, 2, 1'b1);
    @(negedge clk);
    check("b2b_flags_cleared", 32'({if1.busy, if1.is_equal, if1.is_greater, if1.is_less_than,
                                    if1.compare_cycles}), 32'b1_000_0000);
    wait_done(1, bc);

    // Reset in the third scan cycle drops the operation
    @(negedge clk);
    issue(1, 9, 0, 'h0AA, 'h0AA, EQ, 9, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_scan_reset", 32'({if1.busy, if1.is_compare_done, if1.is_equal, if1.is_greater,
                                 if1.is_less_than, if1.compare_cycles, if1.dbg_scan}), 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    run(1, 9, 0, 'h0AA, 'h0AA, EQ, 9);

    repeat (3) @(negedge clk);
    check("u1_queue_drained", exp1_q.size(), 0);
    check("u4_queue_drained", exp4_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
